pixel_position_tracker: RTL and testbench

Pixel-clock-domain stage directly upstream of the single-pixel capture/readback block; it produces that block's 32-bit data word.
Tracks the active-pixel X/Y position from the raw video valid/hsync/vsync stream and measures line length and active lines per frame.
Declares lock once frame geometry is stable, then emits a tagged 32-bit word for the pixel at a programmed target coordinate, once per frame.
Single clock; all configuration arrives as quasi-static inputs already in this clock domain.

---
 rtl/pixel_position_tracker.sv | 203 ++++++++++++++++++++
 tb/tb_pixel_position_tracker.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_position_tracker.sv
// Pixel-domain position tracker: follows X/Y of active pixels, measures frame geometry,
// locks once it is stable and captures one tagged pixel per frame at a target coordinate.
module pixel_position_tracker #(
    parameter int CW = 12,
    parameter int PW = 24
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_pix_valid,
    input  logic          i_hsync,
    input  logic          i_vsync,
    input  logic [PW-1:0] i_pixel,
    input  logic [CW-1:0] i_target_x,
    input  logic [CW-1:0] i_target_y,
    output logic [31:0]   o_data,
    output logic          o_stb,
    output logic [CW-1:0] o_xpos,
    output logic [CW-1:0] o_ypos,
    output logic [CW-1:0] o_line_len,
    output logic [CW-1:0] o_frame_lines,
    output logic          o_locked
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_VERIFY  = 2'd2,
        S_LOCKED  = 2'd3
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t        state_q;
    logic          hsync_q, vsync_q;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          ovf_q, ovf_d;
    logic          ref_valid_q, ref_valid_d;
    logic [CW-1:0] ref_len_q, ref_len_d;
    logic          bad_q, bad_d;
    logic [CW-1:0] meas_len_q, meas_lines_q;
    logic [CW-1:0] line_len_q, frame_lines_q;
    logic [6:0]    frame_count_q, frame_count_d;
    logic          captured_q, captured_d;
    logic [31:0]   data_q;
    logic          stb_q;
    logic          locked_q;

    logic          hs_edge, vs_edge, line_edge, line_active;
    logic [CW-1:0] pix_x, pix_y;
    logic          ovf_now, line_bad;
    logic [CW-1:0] frame_lines, frame_len;
    logic          frame_ok, frame_match, lock_drop, cap_hit;

    always_comb begin
        hs_edge     = i_hsync & ~hsync_q;
        vs_edge     = i_vsync & ~vsync_q;
        line_edge   = hs_edge | vs_edge;
        line_active = line_edge && (x_q != '0);

        // Position of the pixel presented this cycle (an edge cycle pixel is x=0 of the new line)
        pix_x = line_edge ? '0 : x_q;
        if (vs_edge)
            pix_y = '0;
        else if (line_active && (y_q != CNT_MAX))
            pix_y = y_q + 1'b1;
        else
            pix_y = y_q;

        ovf_now = (i_pix_valid && !line_edge && (x_q == CNT_MAX)) ||
                  (line_active && !vs_edge && (y_q == CNT_MAX));

        if (line_edge)
            x_d = {{(CW-1){1'b0}}, i_pix_valid};
        else if (i_pix_valid && (x_q != CNT_MAX))
            x_d = x_q + 1'b1;
        else
            x_d = x_q;
        y_d = pix_y;

        line_bad = line_active &&
                   ((ref_valid_q && (x_q != ref_len_q)) ||
                    ((state_q == S_LOCKED) && (x_q != line_len_q)));

        // Summary of the frame that a vsync edge closes, including a line it finishes
        frame_lines = y_q + {{(CW-1){1'b0}}, line_active};
        if (ref_valid_q)
            frame_len = ref_len_q;
        else if (line_active)
            frame_len = x_q;
        else
            frame_len = '0;
        frame_ok    = !bad_q && !line_bad && !ovf_q && !ovf_now && (frame_lines != '0);
        frame_match = frame_ok && (frame_len == meas_len_q) && (frame_lines == meas_lines_q);

        ref_valid_d = ref_valid_q;
        ref_len_d   = ref_len_q;
        if (vs_edge) begin
            ref_valid_d = 1'b0;
            ref_len_d   = '0;
        end else if (line_active && !ref_valid_q) begin
            ref_valid_d = 1'b1;
            ref_len_d   = x_q;
        end
        bad_d = vs_edge ? 1'b0 : (bad_q | line_bad);
        ovf_d = vs_edge ? 1'b0 : (ovf_q | ovf_now);

        frame_count_d = vs_edge ? frame_count_q + 7'd1 : frame_count_q;

        lock_drop = line_bad || ovf_now ||
                    (vs_edge && (!frame_ok || (frame_lines != frame_lines_q)));

        cap_hit = (state_q == S_LOCKED) && !lock_drop && i_pix_valid &&
                  (vs_edge || !captured_q) &&
                  (pix_x == i_target_x) && (pix_y == i_target_y) &&
                  (i_target_x < line_len_q) && (i_target_y < frame_lines_q);

        captured_d = cap_hit || (captured_q && !vs_edge);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= S_IDLE;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            ovf_q         <= 1'b0;
            ref_valid_q   <= 1'b0;
            ref_len_q     <= '0;
            bad_q         <= 1'b0;
            meas_len_q    <= '0;
            meas_lines_q  <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            frame_count_q <= '0;
            captured_q    <= 1'b0;
            data_q        <= '0;
            stb_q         <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            hsync_q       <= i_hsync;
            vsync_q       <= i_vsync;
            x_q           <= x_d;
            y_q           <= y_d;
            ovf_q         <= ovf_d;
            ref_valid_q   <= ref_valid_d;
            ref_len_q     <= ref_len_d;
            bad_q         <= bad_d;
            frame_count_q <= frame_count_d;
            captured_q    <= captured_d;
            stb_q         <= cap_hit;
            if (cap_hit)
                data_q <= {1'b1, frame_count_d, i_pixel};

            case (state_q)
                S_IDLE: begin
                    if (vs_edge)
                        state_q <= S_MEASURE;
                end
                S_MEASURE: begin
                    if (vs_edge && frame_ok) begin
                        state_q      <= S_VERIFY;
                        meas_len_q   <= frame_len;
                        meas_lines_q <= frame_lines;
                    end
                end
                S_VERIFY: begin
                    if (vs_edge) begin
                        if (frame_match) begin
                            state_q       <= S_LOCKED;
                            locked_q      <= 1'b1;
                            line_len_q    <= frame_len;
                            frame_lines_q <= frame_lines;
                        end else begin
                            state_q <= S_MEASURE;
                        end
                    end
                end
                S_LOCKED: begin
                    // A bad line drops lock immediately, not at the end of the frame
                    if (lock_drop) begin
                        state_q  <= S_MEASURE;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_data        = data_q;
    assign o_stb         = stb_q;
    assign o_xpos        = x_q;
    assign o_ypos        = y_q;
    assign o_line_len    = line_len_q;
    assign o_frame_lines = frame_lines_q;
    assign o_locked      = locked_q;

endmodule

// File: tb/tb_pixel_position_tracker.sv
// Directed bench for pixel_position_tracker: capture expectations go into a queue at
// stimulus time and a negedge monitor pops and compares on every strobe.
module tb_pixel_position_tracker;

    localparam int CW = 12;
    localparam int PW = 24;

    logic          clk;
    logic          srst;
    logic          pix_valid, hsync, vsync;
    logic [PW-1:0] pixel;
    logic [CW-1:0] target_x, target_y;
    logic [31:0]   o_data;
    logic          o_stb;
    logic [CW-1:0] o_xpos, o_ypos, o_line_len, o_frame_lines;
    logic          o_locked;

    int total = 0;
    int bad   = 0;
    int fc_exp = 0;
    bit cap_armed = 0;
    logic [31:0] exp_q[$];

    pixel_position_tracker #(.CW(CW), .PW(PW)) dut (
        .i_clk         (clk),
        .i_reset       (srst),
        .i_pix_valid   (pix_valid),
        .i_hsync       (hsync),
        .i_vsync       (vsync),
        .i_pixel       (pixel),
        .i_target_x    (target_x),
        .i_target_y    (target_y),
        .o_data        (o_data),
        .o_stb         (o_stb),
        .o_xpos        (o_xpos),
        .o_ypos        (o_ypos),
        .o_line_len    (o_line_len),
        .o_frame_lines (o_frame_lines),
        .o_locked      (o_locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (o_stb === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_stb: got %0h expected no strobe", o_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("capture_data", o_data, e);
                $display("capture data=%08h expected=%08h", o_data, e);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] pix_of(input int x, input int y);
        logic [7:0] f8, y8, x8;
        f8 = fc_exp[7:0];
        y8 = y[7:0];
        x8 = x[7:0];
        if (x == 3 && y == 2)
            return 24'hA5C3F0;
        return {f8, y8, x8};
    endfunction

    task automatic push_if_target(input int x, input int y, input logic [23:0] p);
        logic [6:0] f7;
        f7 = fc_exp[6:0];
        if (cap_armed && x == int'(target_x) && y == int'(target_y)) begin
            exp_q.push_back({1'b1, f7, p});
            cap_armed = 0;
        end
    endtask

    task automatic send_pixels(input int x0, input int n, input int y);
        for (int x = x0; x < x0 + n; x++) begin
            pix_valid = 1'b1;
            pixel     = pix_of(x, y);
            push_if_target(x, y, pixel);
            tick();
        end
        pix_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_line(input int n, input int y, input bit chk_unlock);
        if (chk_unlock) check("lock_before_bad_line_end", {31'd0, o_locked}, 32'd1);
        hsync = 1'b1;
        tick();
        if (chk_unlock) check("unlock_after_bad_line_end", {31'd0, o_locked}, 32'd0);
        hsync = 1'b0;
        tick();
        if (n > 0) send_pixels(0, n, y);
    endtask

    task automatic vs_pulse(input bit combined, input int exp_lock);
        fc_exp = (fc_exp + 1) % 128;
        vsync = 1'b1;
        if (combined) begin
            hsync     = 1'b1;
            pix_valid = 1'b1;
            pixel     = pix_of(0, 0);
            push_if_target(0, 0, pixel);
        end
        tick();
        if (exp_lock >= 0) check("lock_after_vsync", {31'd0, o_locked}, exp_lock);
        if (combined) begin
            check("combined_xpos", {20'd0, o_xpos}, 32'd1);
            check("combined_ypos", {20'd0, o_ypos}, 32'd0);
        end
        vsync     = 1'b0;
        hsync     = 1'b0;
        pix_valid = 1'b0;
        tick();
    endtask

    // 4 active lines of 8 pixels and 2 blank lines; short_idx gives a 7-pixel line
    task automatic send_frame(input int short_idx, input bit combined, input int exp_lock);
        vs_pulse(combined, exp_lock);
        if (combined) send_pixels(1, 7, 0);
        else          send_line(8, 0, 1'b0);
        for (int y = 1; y < 4; y++)
            send_line((y == short_idx) ? 7 : 8, y, (short_idx >= 0) && (y == short_idx + 1));
        send_line(0, 4, short_idx == 3);
        send_line(0, 4, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},   o_data, 32'd0);
        check({tag, "_stb"},    {31'd0, o_stb}, 32'd0);
        check({tag, "_locked"}, {31'd0, o_locked}, 32'd0);
        check({tag, "_xpos"},   {20'd0, o_xpos}, 32'd0);
        check({tag, "_ypos"},   {20'd0, o_ypos}, 32'd0);
        check({tag, "_len"},    {20'd0, o_line_len}, 32'd0);
        check({tag, "_lines"},  {20'd0, o_frame_lines}, 32'd0);
    endtask

    initial begin
        srst = 1'b1; pix_valid = 1'b0; hsync = 1'b0; vsync = 1'b0; pixel = '0;
        target_x = 12'd3; target_y = 12'd2;
        repeat (3) tick();
        check_all_zero("reset");
        srst = 1'b0;
        tick();

        // Lock acquisition over three stable frames
        send_frame(-1, 1'b0, 0);
        send_frame(-1, 1'b0, 0);
        check("len_before_lock", {20'd0, o_line_len}, 32'd0);
        cap_armed = 1;
        send_frame(-1, 1'b0, 1);
        check("line_len", {20'd0, o_line_len}, 32'd8);
        check("frame_lines", {20'd0, o_frame_lines}, 32'd4);
        cap_armed = 1;
        send_frame(-1, 1'b0, 1);

        // Short line drops lock immediately; two clean frames relock
        cap_armed = 0;
        send_frame(1, 1'b0, 1);
        send_frame(-1, 1'b0, 0);
        send_frame(-1, 1'b0, 0);
        cap_armed = 1;
        send_frame(-1, 1'b0, 1);

        // Target beyond measured line length never captures
        target_x = 12'd20; target_y = 12'd2;
        cap_armed = 0;
        for (int f = 0; f < 3; f++) send_frame(-1, 1'b0, 1);
        check("data_held_out_of_range", o_data, {1'b1, 7'd8, 24'hA5C3F0});

        // Simultaneous hsync and vsync rise with a valid pixel at (0,0)
        target_x = 12'd0; target_y = 12'd0;
        cap_armed = 1;
        send_frame(-1, 1'b1, 1);
        cap_armed = 1;
        send_frame(-1, 1'b0, 1);

        // Reset in the middle of a frame
        target_x = 12'd3; target_y = 12'd2;
        cap_armed = 0;
        vs_pulse(1'b0, 1);
        send_line(8, 0, 1'b0);
        send_line(0, 1, 1'b0);
        srst = 1'b1;
        pix_valid = 1'b1;
        pixel = 24'h123456;
        repeat (3) tick();
        check_all_zero("midreset");
        srst = 1'b0;
        pix_valid = 1'b0;
        fc_exp = 0;
        tick();
        send_pixels(0, 5, 9);
        send_frame(-1, 1'b0, 0);
        send_frame(-1, 1'b0, 0);
        check("len_before_relock", {20'd0, o_line_len}, 32'd0);
        cap_armed = 1;
        send_frame(-1, 1'b0, 1);
        check("relock_len", {20'd0, o_line_len}, 32'd8);

        repeat (4) tick();
        check("pending_captures", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
